// File: rtl/sfp_norm_row.sv
// sfp_norm_row
// Special-function stage between the psum memory read port and the write-back path.
// Accepts one row of signed partial sums and sums their absolute values.
// It then divides each lane's absolute value by ((sum >> shift) + 1).
// The normalized row is returned through a valid/ready handshake.
// All arithmetic is lane-serial: one lane per cycle while accumulating, then a
// restoring divider producing one quotient bit per cycle.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-low reset
//   in_valid   in_data holds a valid row
//   in_ready   block can accept a row (IDLE only)
//   in_data    col signed lanes of bw_psum bits, lane i at [bw_psum*(i+1)-1 : bw_psum*i]
//   out_valid  out_data / sum_out are valid
//   out_ready  consumer takes the result
//   out_data   col unsigned normalized lanes, same packing as in_data
//   sum_out    sum of absolute values of the current row
//   busy       high in any state other than IDLE
module sfp_norm_row #(
    parameter int bw_psum = 20,
    parameter int col     = 8,
    parameter int sum_bw  = bw_psum + 4,
    parameter int shift   = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [bw_psum*col-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [bw_psum*col-1:0]   out_data,
    output logic [sum_bw-1:0]        sum_out,
    output logic                     busy
);

    localparam int div_bw = sum_bw - shift + 1;
    localparam int idx_bw = $clog2(col + 1);
    localparam int bit_bw = $clog2(bw_psum);

    localparam logic [idx_bw-1:0]  last_lane = idx_bw'(col - 1);
    localparam logic [idx_bw-1:0]  div_latch = idx_bw'(col);
    localparam logic [bit_bw-1:0]  top_bit   = bit_bw'(bw_psum - 1);
    localparam logic [bw_psum-1:0] one_lane  = bw_psum'(1);
    localparam logic [div_bw-1:0]  one_div   = div_bw'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [bw_psum*col-1:0] row_q;
    logic [bw_psum*col-1:0] out_q;
    logic [sum_bw-1:0]      acc;
    logic [div_bw-1:0]      div_q;
    logic [div_bw-1:0]      rem;
    logic [bw_psum-2:0]     quot;
    logic [idx_bw-1:0]      lane_idx;
    logic [bit_bw-1:0]      bit_idx;

    logic [bw_psum-1:0]     cur_lane;
    logic [bw_psum-1:0]     abs_lane;
    logic [div_bw-1:0]      div_calc;
    logic [bit_bw-1:0]      bit_pos;
    logic                   dbit;
    logic [div_bw-1:0]      rem_base;
    logic [div_bw:0]        rem_shift;
    logic [div_bw:0]        div_ext;
    logic                   ge;
    logic [div_bw-1:0]      rem_next;
    logic [bw_psum-1:0]     quot_next;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = out_q;
    assign sum_out   = acc;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. ACC spends one extra cycle (lane_idx == col) latching
    // the divisor, so DIV always starts from a registered divisor.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = ACC;
            ACC:  if (lane_idx == div_latch) state_next = DIV;
            DIV:  if ((lane_idx == last_lane) && (bit_idx == top_bit)) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane selection and absolute value; the most-negative input negates to
    // 2^(bw_psum-1), which is exact as an unsigned bw_psum-bit value.
    always_comb begin
        cur_lane = '0;
        for (int i = 0; i < col; i++) begin
            if (lane_idx == idx_bw'(i)) cur_lane = row_q[i*bw_psum +: bw_psum];
        end
        abs_lane = cur_lane[bw_psum-1] ? ((~cur_lane) + one_lane) : cur_lane;
    end

    // Divisor is never zero thanks to the +1.
    assign div_calc = {1'b0, acc[sum_bw-1:shift]} + one_div;

    // One restoring-divide step. The dividend bit is taken straight from the
    // latched row MSB first; the partial remainder restarts at zero per lane.
    always_comb begin
        bit_pos   = top_bit - bit_idx;
        dbit      = abs_lane[bit_pos];
        rem_base  = (bit_idx == '0) ? '0 : rem;
        rem_shift = {rem_base, dbit};
        div_ext   = {1'b0, div_q};
        ge        = (rem_shift >= div_ext);
        rem_next  = ge ? div_bw'(rem_shift - div_ext) : rem_shift[div_bw-1:0];
        quot_next = {quot, ge};
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            row_q    <= '0;
            out_q    <= '0;
            acc      <= '0;
            div_q    <= '0;
            rem      <= '0;
            quot     <= '0;
            lane_idx <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        row_q    <= in_data;
                        acc      <= '0;
                        out_q    <= '0;
                        lane_idx <= '0;
                        bit_idx  <= '0;
                    end
                end
                ACC: begin
                    if (lane_idx == div_latch) begin
                        div_q    <= div_calc;
                        lane_idx <= '0;
                        bit_idx  <= '0;
                    end else begin
                        acc      <= acc + {{(sum_bw-bw_psum){1'b0}}, abs_lane};
                        lane_idx <= lane_idx + 1'b1;
                    end
                end
                DIV: begin
                    rem  <= rem_next;
                    quot <= quot_next[bw_psum-2:0];
                    if (bit_idx == top_bit) begin
                        for (int i = 0; i < col; i++) begin
                            if (lane_idx == idx_bw'(i)) out_q[i*bw_psum +: bw_psum] <= quot_next;
                        end
                        bit_idx  <= '0;
                        lane_idx <= lane_idx + 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfp_norm_row.sv
// tb_sfp_norm_row
// Directed, table-driven bench for sfp_norm_row: a vector table of rows with
// hand-computed sums and quotients, plus hand-written sequences for
// backpressure in DONE and a reset that lands in the middle of DIV.
module tb_sfp_norm_row;

    localparam int bw_psum = 20;
    localparam int col     = 8;
    localparam int sum_bw  = bw_psum + 4;
    localparam int shift   = 7;
    localparam int latency = col * (bw_psum + 1) + 1;
    localparam int timeout = 400;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [bw_psum*col-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [bw_psum*col-1:0] out_data;
    logic [sum_bw-1:0]      sum_out;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string                  name;
        logic [bw_psum*col-1:0] data;
        logic [sum_bw-1:0]      exp_sum;
        logic [bw_psum*col-1:0] exp_out;
    } vec_t;

    vec_t vecs [4];

    sfp_norm_row #(
        .bw_psum(bw_psum),
        .col    (col),
        .sum_bw (sum_bw),
        .shift  (shift)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .sum_out  (sum_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack eight signed integers into a row, lane 0 in the low bits.
    function automatic logic [bw_psum*col-1:0] pack_row(input int v [col]);
        logic [bw_psum*col-1:0] r;
        r = '0;
        for (int i = 0; i < col; i++) r[i*bw_psum +: bw_psum] = bw_psum'(v[i]);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [191:0] actual,
                               input logic [191:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one row, count edges from acceptance until out_valid appears,
    // and compare latency and results. Leaves the DUT sitting in DONE.
    task automatic applyStimulus(input vec_t v);
        int cnt;
        in_data  = v.data;
        in_valid = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < timeout) begin
            tick();
            cnt++;
        end
        checkOutput({v.name, " in_ready"}, 192'(in_ready), 192'(1));
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        checkOutput({v.name, " busy_after_accept"}, 192'(busy), 192'(1));
        cnt = 0;
        while (!out_valid && cnt < timeout) begin
            tick();
            cnt++;
        end
        checkOutput({v.name, " latency"}, 192'(cnt), 192'(latency));
        checkOutput({v.name, " sum_out"}, 192'(sum_out), 192'(v.exp_sum));
        for (int i = 0; i < col; i++)
            checkOutput($sformatf("%s lane%0d", v.name, i),
                        192'(out_data[i*bw_psum +: bw_psum]),
                        192'(v.exp_out[i*bw_psum +: bw_psum]));
        checkOutput({v.name, " in_ready_done"}, 192'(in_ready), 192'(0));
    endtask

    task automatic release_done();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int l [col];
        logic [bw_psum*col-1:0] held_data;
        logic [sum_bw-1:0]      held_sum;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Table: all +100 -> sum 800, div 7, lanes 14
        l = '{100, 100, 100, 100, 100, 100, 100, 100};
        vecs[0].name = "all100";  vecs[0].data = pack_row(l); vecs[0].exp_sum = 24'd800;
        l = '{14, 14, 14, 14, 14, 14, 14, 14};
        vecs[0].exp_out = pack_row(l);
        // {-300,+300,0..} -> sum 600, div 5, {60,60,0..}
        l = '{-300, 300, 0, 0, 0, 0, 0, 0};
        vecs[1].name = "pm300";   vecs[1].data = pack_row(l); vecs[1].exp_sum = 24'd600;
        l = '{60, 60, 0, 0, 0, 0, 0, 0};
        vecs[1].exp_out = pack_row(l);
        // zero row -> sum 0, div 1, all zero
        l = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].name = "zeros";   vecs[2].data = pack_row(l); vecs[2].exp_sum = 24'd0;
        vecs[2].exp_out = pack_row(l);
        // most-negative lane 0 -> sum 524288, div 4097, lane0 127
        l = '{-524288, 0, 0, 0, 0, 0, 0, 0};
        vecs[3].name = "minneg";  vecs[3].data = pack_row(l); vecs[3].exp_sum = 24'd524288;
        l = '{127, 0, 0, 0, 0, 0, 0, 0};
        vecs[3].exp_out = pack_row(l);

        tick();
        tick();
        checkOutput("reset in_ready", 192'(in_ready), 192'(1));
        checkOutput("reset out_valid", 192'(out_valid), 192'(0));
        checkOutput("reset busy", 192'(busy), 192'(0));
        checkOutput("reset out_data", 192'(out_data), 192'(0));
        checkOutput("reset sum_out", 192'(sum_out), 192'(0));
        reset = 1'b1;
        tick();

        for (int k = 0; k < 4; k++) begin
            applyStimulus(vecs[k]);
            release_done();
            checkOutput({vecs[k].name, " idle_after"}, 192'(in_ready), 192'(1));
        end

        // Backpressure: stay in DONE for 10 cycles with out_ready low.
        applyStimulus(vecs[1]);
        held_data = out_data;
        held_sum  = sum_out;
        for (int c = 0; c < 10; c++) tick();
        checkOutput("bp out_data", 192'(out_data), 192'(vecs[1].exp_out));
        checkOutput("bp sum_out", 192'(sum_out), 192'(held_sum));
        checkOutput("bp held_data", 192'(out_data), 192'(held_data));
        checkOutput("bp in_ready", 192'(in_ready), 192'(0));
        checkOutput("bp busy", 192'(busy), 192'(1));
        checkOutput("bp out_valid", 192'(out_valid), 192'(1));
        release_done();
        checkOutput("bp idle in_ready", 192'(in_ready), 192'(1));
        checkOutput("bp idle out_valid", 192'(out_valid), 192'(0));
        in_data  = vecs[0].data;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("bp second accepted", 192'(busy), 192'(1));

        // Reset the second row mid-DIV (ACC is 9 edges; 50 edges is well into DIV).
        for (int c = 0; c < 50; c++) tick();
        checkOutput("middiv busy", 192'(busy), 192'(1));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("middiv in_ready", 192'(in_ready), 192'(1));
        checkOutput("middiv out_valid", 192'(out_valid), 192'(0));
        checkOutput("middiv busy_low", 192'(busy), 192'(0));
        checkOutput("middiv out_data", 192'(out_data), 192'(0));
        checkOutput("middiv sum_out", 192'(sum_out), 192'(0));
        tick();
        applyStimulus(vecs[0]);
        release_done();

        // Reset after DONE clears outputs.
        applyStimulus(vecs[3]);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("postdone out_data", 192'(out_data), 192'(0));
        checkOutput("postdone sum_out", 192'(sum_out), 192'(0));
        checkOutput("postdone out_valid", 192'(out_valid), 192'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
